// File: rtl/div_sequencer.sv
// Iterative 32-cycle restoring divider covering DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] r
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, r_q;
  logic            sel_rem_q, neg_quo_q, neg_rem_q;

  logic            a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_d, res_d, quo_d, rem_d;
  logic [XLEN:0]   shl, diff;

  // op[0] set means unsigned, op[1] set means remainder
  always_comb begin
    a_neg  = ~op[0] & a[XLEN-1];
    b_neg  = ~op[0] & b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    div0   = (b == '0);
    ovf    = ~op[0] & (a == SMIN) & (b == '1);
    spec_d = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : SMIN);
  end

  // One restoring step: the trial subtract's borrow decides the quotient bit
  always_comb begin
    shl   = {rem_q, quo_q[XLEN-1]};
    diff  = shl - {1'b0, dvs_q};
    rem_d = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
    res_d = sel_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                      : (neg_quo_q ? -quo_q : quo_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sel_rem_q <= op[1];
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          if (div0 || ovf) begin
            r_q     <= spec_d;
            state_q <= DONE;
          end else begin
            quo_q   <= a_mag;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            cnt_q   <= CW'(XLEN-1);
            state_q <= CALC;
          end
        end
        CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          r_q     <= res_d;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign stall = ~rst & (((state_q == IDLE) & start & ~flush) |
                         (state_q == CALC) | (state_q == FIX));
  assign r     = r_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency/result model checked every cycle
// plus literal expectations for each directed vector.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] r;

  int total = 0;
  int bad   = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .stall(stall), .r(r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'h0) || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'h0) return o[1] ? x : 32'hFFFFFFFF;
    if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return o[1] ? 32'h0 : 32'h80000000;
    case (o)
      2'd0:    return $signed(x) / $signed(y);
      2'd1:    return x / y;
      2'd2:    return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  // Model: m_left counts cycles still owed to the current operation, the last
  // of which is the done cycle; 0 means idle.
  int          m_left = 0;
  logic [31:0] m_r    = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_r    <= 32'h0;
    end else if (flush) begin
      m_left <= 0;
    end else if (m_left == 0) begin
      if (start) begin
        if (is_special(op, a, b)) begin
          m_left <= 1;
          m_r    <= ref_res(op, a, b);
        end else begin
          m_left <= 34;
          m_pend <= ref_res(op, a, b);
        end
      end
    end else begin
      if (m_left == 2) m_r <= m_pend;
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("busy",  {31'b0, busy},  {31'b0, m_left != 0});
    chk("done",  {31'b0, done},  {31'b0, m_left == 1});
    chk("stall", {31'b0, stall},
        {31'b0, !rst && ((m_left == 0 && start && !flush) || m_left > 1)});
    chk("r", r, m_r);
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input int el);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~x; b = x;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    chk({nm, " latency"}, 32'(n), 32'(el));
    chk({nm, " result"}, r, er);
    chk({nm, " stall@done"}, {31'b0, stall}, 32'h0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
    #1;
    chk("rst busy",  {31'b0, busy},  32'h0);
    chk("rst done",  {31'b0, done},  32'h0);
    chk("rst r",     r,              32'h0);
    start = 1'b1;
    #1 chk("rst stall gated", {31'b0, stall}, 32'h0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    run_op("div -7/2",     2'd0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34);
    run_op("rem -7/2",     2'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34);
    run_op("remu -7/2",    2'd3, 32'hFFFFFFF9, 32'h2,        32'h00000001, 34);
    run_op("divu /0",      2'd1, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1);
    run_op("remu 5/0",     2'd3, 32'h5,        32'h0,        32'h5,        1);
    run_op("div ovf",      2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem ovf",      2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run_op("divu 100/7",   2'd1, 32'd100,      32'd7,        32'd14,       34);
    run_op("div 100/-7",   2'd0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
    run_op("rem -100/7",   2'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34);
    run_op("remu max/10",  2'd3, 32'hFFFFFFFF, 32'd10,       32'd5,        34);
    run_op("div min/2",    2'd0, 32'h80000000, 32'd2,        32'hC0000000, 34);
    run_op("divu min/max", 2'd1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34);
    run_op("rem 0/0",      2'd2, 32'h0,        32'h0,        32'h0,        1);
    run_op("div 1000/3",   2'd0, 32'd1000,     32'd3,        32'd333,      34);

    // flush overrides a simultaneous start in IDLE
    op = 2'd1; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush beats start", {31'b0, busy}, 32'h0);
    #1;

    // flush in the 10th CALC cycle
    op = 2'd0; a = 32'd999; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush idle", {31'b0, busy}, 32'h0);
    chk("flush keeps r", r, 32'd333);
    #1;
    run_op("divu after flush", 2'd1, 32'd1000, 32'd3, 32'd333, 34);

    // reset pulse between edges in the 20th CALC cycle
    op = 2'd3; a = 32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy",  {31'b0, busy},  32'h0);
    chk("midrst stall", {31'b0, stall}, 32'h0);
    chk("midrst done",  {31'b0, done},  32'h0);
    chk("midrst r",     r,              32'h0);
    #1 rst = 1'b0;
    run_op("rem after rst", 2'd2, 32'd77, 32'hFFFFFFFB, 32'd2, 34);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
